// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder with running disparity chained lane 0 -> lane N-1 each cycle.
// Optional `ENC_KERR_EN adds the registered TxKErr flag for invalid K requests.
module enc8b10b_lanes #(
  parameter int unsigned NUM_BYTES = 2,
  parameter logic [7:0]  IDLE_CHAR = 8'hBC
) (
  input  logic                    BitCLK_10,
  input  logic                    Reset,
  input  logic                    TxValid,
  output logic                    TxReady,
  input  logic [NUM_BYTES-1:0]    TxDataK,
  input  logic [8*NUM_BYTES-1:0]  TxParallel_8,
  input  logic                    TxOutReady,
  output logic [10*NUM_BYTES-1:0] TxParallel_10,
  output logic                    TxValid_10,
  output logic                    RunDisp
`ifdef ENC_KERR_EN
  ,
  output logic [NUM_BYTES-1:0]    TxKErr
`endif
);

  function automatic logic k_valid(input logic [7:0] d);
    return (d[4:0] == 5'd28) || (d == 8'hF7) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
  endfunction

  // Returns {rd_after, symbol}; tables are written abcdei / fghj (a, f as MSB) then bit-reversed.
  function automatic logic [10:0] enc_byte(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       flip6;
    logic       flip4;
    logic       rd6;
    logic       comp4;
    logic       use_a7;
    x = d[4:0];
    y = d[7:5];
    c6 = '0;
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
      default: c6 = '0;
    endcase
    if (k && x == 5'd28) c6 = 6'b001111;
    flip6 = ($countones(c6) != 3);
    // D.7 is neutral yet still has distinct RD-/RD+ forms
    if (rd_in && (flip6 || x == 5'd7)) c6 = ~c6;
    rd6 = rd_in ^ flip6;

    use_a7 = (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    c4 = '0;
    if (k) begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;
        3'd2: c4 = 4'b1010;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;
        3'd6: c4 = 4'b1001;  3'd7: c4 = 4'b0111;
        default: c4 = '0;
      endcase
      comp4 = 1'b1;
    end else begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;
        3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;
        3'd6: c4 = 4'b0110;  3'd7: c4 = use_a7 ? 4'b0111 : 4'b1110;
        default: c4 = '0;
      endcase
      comp4 = (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
    end
    flip4 = ($countones(c4) != 2);
    if (rd6 && comp4) c4 = ~c4;
    return {rd6 ^ flip4,
            c4[0], c4[1], c4[2], c4[3],
            c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  endfunction

  logic [10*NUM_BYTES-1:0] sym_next;
  logic                    rd_next;
  logic                    rd_chain;
  logic [10:0]             res;
  logic [7:0]              lane_byte;
  logic                    lane_k;
`ifdef ENC_KERR_EN
  logic [NUM_BYTES-1:0]    kerr_next;
`endif

  assign TxReady = TxOutReady;

  always_comb begin
    sym_next  = '0;
    rd_chain  = RunDisp;
    res       = '0;
    lane_byte = '0;
    lane_k    = 1'b0;
`ifdef ENC_KERR_EN
    kerr_next = '0;
`endif
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      lane_byte = TxValid ? TxParallel_8[8*i +: 8] : IDLE_CHAR;
      lane_k    = TxValid ? TxDataK[i] : 1'b1;
      res       = enc_byte(lane_byte, lane_k && k_valid(lane_byte), rd_chain);
      sym_next[10*i +: 10] = res[9:0];
      rd_chain  = res[10];
`ifdef ENC_KERR_EN
      kerr_next[i] = TxValid && TxDataK[i] && !k_valid(lane_byte);
`endif
    end
    rd_next = rd_chain;
  end

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      TxParallel_10 <= '0;
      TxValid_10    <= 1'b0;
      RunDisp       <= 1'b0;
`ifdef ENC_KERR_EN
      TxKErr        <= '0;
`endif
    end else if (TxOutReady) begin
      TxParallel_10 <= sym_next;
      TxValid_10    <= TxValid;
      RunDisp       <= rd_next;
`ifdef ENC_KERR_EN
      TxKErr        <= kerr_next;
`endif
    end
  end

endmodule
